mac_operand_sequencer: RTL and testbench
========================================

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 Parameter DIM, default 3: square matrix dimension, legal range 1..32.
REQ-002 Parameter DW, default 8: unsigned operand width.
REQ-003 Parameter AW, default $clog2(DIM*DIM) (minimum 1): element address width.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset; one clock, synchronous and active-high.
REQ-006 start  in  1  level; sampled only in IDLE; begins C = A x B.
REQ-007 opReq  out  1  one-cycle request for the next MAC step; drives the operate-signal controller's signal input.
REQ-008 genAddr  in  1  one-cycle pulse from the controller: present operand addresses.
REQ-009 acum  in  1  one-cycle pulse from the controller: operand data valid, accumulate.
REQ-010 addrA, addrB  out  AW  registered read addresses of matrix A and matrix B.
REQ-011 dataA, dataB  in  DW  read data from synchronous RAM with 1-cycle latency.
REQ-012 wrEn  out  1  one-cycle write strobe for a C element.
REQ-013 wrAddr  out  AW  C element address, valid while wrEn=1.
REQ-014 wrData  out  2*DW+$clog2(DIM)+1  C element value, valid while wrEn=1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse after the last C element is written.

Function
REQ-017 Indices i (row), j (column), k (inner) shall each count 0..DIM-1; k is the innermost loop, then j, then i.
REQ-018 Addressing shall be row-major: addrA=i*DIM+k, addrB=k*DIM+j, wrAddr=i*DIM+j.
REQ-019 States: IDLE, REQ, WAITADDR, WAITACC, WRITE, FINISH.
REQ-020 IDLE: when start=1, clear i, j, k and acc, then go to REQ; otherwise stay in IDLE.
REQ-021 REQ: assert opReq for exactly this one cycle, then go to WAITADDR.
REQ-022 WAITADDR: on genAddr=1, register addrA/addrB from the current i, j, k (valid from the next cycle) and go to WAITACC; otherwise hold.
REQ-023 WAITACC: on acum=1, acc <= dataA*dataB when k=0, else acc + dataA*dataB; then if k=DIM-1 go to WRITE, else increment k and go to REQ.
REQ-024 WRITE: drive wrEn=1, wrAddr=i*DIM+j and wrData equal to the final acc; clear k; advance j, and on j wrap advance i; go to FINISH if (i,j)=(DIM-1,DIM-1), else go to REQ.
REQ-025 FINISH: pulse done=1 for one cycle, then go to IDLE.
REQ-026 Arithmetic shall be unsigned and full-width; acc shall not overflow for any operands.
REQ-027 genAddr or acum arriving outside its own wait state shall be ignored, with no state or data change.
REQ-028 start while busy=1 shall be ignored.
REQ-029 genAddr and acum asserted together in WAITADDR: only genAddr acts.
REQ-030 DIM=1: exactly one MAC, one write to address 0, then done.
REQ-031 Counts per run: opReq asserted DIM^3 times; wrEn asserted DIM^2 times, at increasing wrAddr 0..DIM^2-1.
REQ-032 opReq, wrEn and done shall each be a single-cycle pulse.

Reset
REQ-033 rst=1 at a clock edge shall force IDLE and clear i, j, k and acc.
REQ-034 rst=1 shall set opReq, wrEn, done and busy to 0, and addrA, addrB, wrAddr and wrData to 0.
REQ-035 Reset mid-run shall abort the run with no further wrEn and no done; a new start restarts from (0,0,0).

Structure
REQ-036 A shared package shall hold the state encoding localparams and an address-width function (clog2 with a minimum of 1).
REQ-037 Sub-module mat_index_counter shall hold the nested i/j/k counters, with inputs clr, incK and nextElem, and outputs i, j, k, lastK and lastElem.
REQ-038 The multiplier and accumulator stay in the top module; the RAMs are external.

Verification
REQ-039 DIM=2, A=identity, B=[[1,2],[3,4]], start pulse -> wrEn x4 at addresses 0,1,2,3 with data 1,2,3,4, then a single done pulse.
REQ-040 DIM=3, DW=8, all operands 255 -> all 9 writes have wrData=195075; opReq counted 27 times.
REQ-041 acum pulse in IDLE, and genAddr pulse in WAITACC -> no change to state, acc or outputs.
REQ-042 rst asserted after the 2nd write of DIM=2 -> busy=0 next cycle, no further wrEn, no done; restart produces results identical to REQ-039.
REQ-043 start held high for the whole run -> exactly one run; a second run begins only after FINISH returns to IDLE.
REQ-044 DIM=1, A=[7], B=[9] -> one write, address 0, data 63, then done.

Source files
------------

// File: rtl/mac_operand_sequencer_pkg.sv
// mac_operand_sequencer_pkg: shared state encoding and address-width helper
package mac_operand_sequencer_pkg;
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_REQ      = 3'd1;
   localparam logic [2:0] S_WAITADDR = 3'd2;
   localparam logic [2:0] S_WAITACC  = 3'd3;
   localparam logic [2:0] S_WRITE    = 3'd4;
   localparam logic [2:0] S_FINISH   = 3'd5;
   typedef enum logic [2:0] {
      IDLE     = S_IDLE,
      REQ      = S_REQ,
      WAITADDR = S_WAITADDR,
      WAITACC  = S_WAITACC,
      WRITE    = S_WRITE,
      FINISH   = S_FINISH
   } state_t;
   function automatic int addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if: controller handshake, RAM read ports and C write port
interface mac_operand_sequencer_if #(
   parameter int DIM = 3,
   parameter int DW = 8,
   parameter int AW = mac_operand_sequencer_pkg::addr_w(DIM * DIM)
);
   localparam int CW = 2 * DW + $clog2(DIM) + 1;
   logic start;
   logic opReq;
   logic genAddr;
   logic acum;
   logic [AW-1:0] addrA;
   logic [AW-1:0] addrB;
   logic [DW-1:0] dataA;
   logic [DW-1:0] dataB;
   logic wrEn;
   logic [AW-1:0] wrAddr;
   logic [CW-1:0] wrData;
   logic busy;
   logic done;
   modport slave (
      input start, genAddr, acum, dataA, dataB,
      output opReq, addrA, addrB, wrEn, wrAddr, wrData, busy, done
   );
   modport master (
      output start, genAddr, acum, dataA, dataB,
      input opReq, addrA, addrB, wrEn, wrAddr, wrData, busy, done
   );
endinterface

// File: rtl/mac_operand_sequencer_mat_index_counter.sv
// mat_index_counter: nested i/j/k loop counters, k innermost
module mat_index_counter
   import mac_operand_sequencer_pkg::*;
#(
   parameter int DIM = 3,
   parameter int IW = addr_w(DIM)
) (
   input logic clk,
   input logic rst,
   input logic clr,
   input logic incK,
   input logic nextElem,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   output logic [IW-1:0] k,
   output logic lastK,
   output logic lastElem
);
   localparam logic [IW-1:0] MAX = IW'(DIM - 1);
   assign lastK = k == MAX;
   assign lastElem = (i == MAX) && (j == MAX);
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (nextElem) begin
         k <= '0;
         j <= (j == MAX) ? '0 : j + 1'b1;
         i <= (j == MAX) ? ((i == MAX) ? '0 : i + 1'b1) : i;
      end else if (incK) begin
         k <= k + 1'b1;
      end
   end
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: steps an external MAC controller through C = A x B, one operand pair per request
module mac_operand_sequencer
   import mac_operand_sequencer_pkg::*;
#(
   parameter int DIM = 3,
   parameter int DW = 8,
   parameter int AW = addr_w(DIM * DIM)
) (
   input logic clk,
   input logic rst,
   mac_operand_sequencer_if.slave bus
);
   localparam int IW = addr_w(DIM);
   localparam int CW = 2 * DW + $clog2(DIM) + 1;
   state_t state;
   logic [IW-1:0] i, j, k;
   logic last_k, last_elem;
   logic clr, inc_k, next_elem;
   logic [CW-1:0] acc, acc_next;
   assign clr = (state == IDLE) && bus.start;
   assign inc_k = (state == WAITACC) && bus.acum && !last_k;
   assign next_elem = state == WRITE;
   // k=0 starts a fresh dot product, so the previous element's sum is discarded here
   assign acc_next = ((k == '0) ? CW'(0) : acc) + CW'(bus.dataA) * CW'(bus.dataB);
   mat_index_counter #(.DIM(DIM), .IW(IW)) cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .incK(inc_k),
      .nextElem(next_elem),
      .i(i),
      .j(j),
      .k(k),
      .lastK(last_k),
      .lastElem(last_elem)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc <= '0;
         bus.opReq <= 1'b0;
         bus.wrEn <= 1'b0;
         bus.done <= 1'b0;
         bus.busy <= 1'b0;
         bus.addrA <= '0;
         bus.addrB <= '0;
         bus.wrAddr <= '0;
         bus.wrData <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               acc <= '0;
               bus.busy <= 1'b1;
               bus.opReq <= 1'b1;
               state <= REQ;
            end
            REQ: begin
               bus.opReq <= 1'b0;
               state <= WAITADDR;
            end
            WAITADDR: if (bus.genAddr) begin
               bus.addrA <= AW'(i) * AW'(DIM) + AW'(k);
               bus.addrB <= AW'(k) * AW'(DIM) + AW'(j);
               state <= WAITACC;
            end
            WAITACC: if (bus.acum) begin
               acc <= acc_next;
               if (last_k) begin
                  bus.wrEn <= 1'b1;
                  bus.wrAddr <= AW'(i) * AW'(DIM) + AW'(j);
                  bus.wrData <= acc_next;
                  state <= WRITE;
               end else begin
                  bus.opReq <= 1'b1;
                  state <= REQ;
               end
            end
            WRITE: begin
               bus.wrEn <= 1'b0;
               if (last_elem) begin
                  bus.done <= 1'b1;
                  state <= FINISH;
               end else begin
                  bus.opReq <= 1'b1;
                  state <= REQ;
               end
            end
            FINISH: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed matrix vectors on DIM=2/3/1 instances plus reset, start and stray-pulse cases
module tb_mac_operand_sequencer;
   localparam int NI = 3;
   typedef struct packed {
      int g;
      bit nz;
      logic [0:8][7:0] a;
      logic [0:8][7:0] b;
      logic [0:8][31:0] c;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start [NI] = '{1'b0, 1'b0, 1'b0};
   logic ga_m [NI] = '{1'b0, 1'b0, 1'b0};
   logic ac_m [NI] = '{1'b0, 1'b0, 1'b0};
   logic noise [NI] = '{1'b0, 1'b0, 1'b0};
   int mem_a [NI][9];
   int mem_b [NI][9];
   logic o_busy [NI], o_op [NI], o_wr [NI], o_done [NI];
   int o_addr_a [NI], o_addr_b [NI], o_wra [NI], o_wrd [NI];
   int op_cnt [NI] = '{0, 0, 0};
   int wr_cnt [NI] = '{0, 0, 0};
   int done_cnt [NI] = '{0, 0, 0};
   int pulse_err [NI] = '{0, 0, 0};
   logic p_op [NI], p_wr [NI], p_done [NI];
   int log_a [NI][64];
   int log_d [NI][64];
   int n_cmp = 0;
   int n_fail = 0;
   vec_t v [7];
   always #5 clk = ~clk;
   for (genvar g = 0; g < NI; g++) begin : c
      localparam int D = (g == 0) ? 2 : (g == 1) ? 3 : 1;
      localparam int A = (D * D < 2) ? 1 : $clog2(D * D);
      logic ga = 1'b0;
      logic ac = 1'b0;
      mac_operand_sequencer_if #(.DIM(D), .DW(8), .AW(A)) bus ();
      mac_operand_sequencer #(.DIM(D), .DW(8), .AW(A)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
      assign bus.start = start[g];
      assign bus.genAddr = ga | ga_m[g];
      assign bus.acum = ac | ac_m[g];
      assign o_busy[g] = bus.busy;
      assign o_op[g] = bus.opReq;
      assign o_wr[g] = bus.wrEn;
      assign o_done[g] = bus.done;
      assign o_addr_a[g] = int'(bus.addrA);
      assign o_addr_b[g] = int'(bus.addrB);
      assign o_wra[g] = int'(bus.wrAddr);
      assign o_wrd[g] = int'(bus.wrData);
      always @(posedge clk) begin
         bus.dataA <= 8'(mem_a[g][bus.addrA]);
         bus.dataB <= 8'(mem_b[g][bus.addrB]);
      end
      // controller: genAddr one cycle into WAITADDR, acum once RAM data is out; noise adds stray pulses
      initial forever begin
         if (bus.opReq === 1'b1) begin
            @(posedge clk); #1;
            ga = 1'b1;
            ac = noise[g];
            @(posedge clk); #1;
            ga = noise[g];
            ac = 1'b0;
            @(posedge clk); #1;
            ga = 1'b0;
            ac = 1'b1;
            @(posedge clk); #1;
            ac = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
   end
   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (!rst) begin
            if (o_wr[g]) begin
               if (wr_cnt[g] < 64) begin
                  log_a[g][wr_cnt[g]] <= o_wra[g];
                  log_d[g][wr_cnt[g]] <= o_wrd[g];
               end
               wr_cnt[g] <= wr_cnt[g] + 1;
            end
            if (o_op[g]) op_cnt[g] <= op_cnt[g] + 1;
            if (o_done[g]) done_cnt[g] <= done_cnt[g] + 1;
            if ((o_op[g] && p_op[g]) || (o_wr[g] && p_wr[g]) || (o_done[g] && p_done[g]))
               pulse_err[g] <= pulse_err[g] + 1;
         end
         p_op[g] <= o_op[g];
         p_wr[g] <= o_wr[g];
         p_done[g] <= o_done[g];
      end
   end
   function automatic int dim_of(input int g);
      return (g == 0) ? 2 : (g == 1) ? 3 : 1;
   endfunction
   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic wait_done(input int g, input string name);
      int n;
      n = 0;
      while (!o_done[g] && n < 3000) begin
         tick();
         n++;
      end
      if (!o_done[g]) check({name, " done timeout"}, 0, 1);
   endtask
   task automatic load(input vec_t t);
      for (int x = 0; x < 9; x++) begin
         mem_a[t.g][x] = int'(t.a[x]);
         mem_b[t.g][x] = int'(t.b[x]);
      end
      noise[t.g] = t.nz;
   endtask
   task automatic check_log(input vec_t t, input int base, input string name);
      int d;
      d = dim_of(t.g);
      for (int x = 0; x < d * d; x++) begin
         check($sformatf("%s wrAddr[%0d]", name, x), log_a[t.g][base + x], x);
         check($sformatf("%s wrData[%0d]", name, x), log_d[t.g][base + x], int'(t.c[x]));
      end
   endtask
   task automatic run(input vec_t t, input string name);
      int d, b0, o0, n0;
      d = dim_of(t.g);
      b0 = wr_cnt[t.g];
      o0 = op_cnt[t.g];
      n0 = done_cnt[t.g];
      load(t);
      start[t.g] = 1'b1;
      tick();
      start[t.g] = 1'b0;
      wait_done(t.g, name);
      tick();
      tick();
      check({name, " busy after"}, int'(o_busy[t.g]), 0);
      check({name, " wrEn count"}, wr_cnt[t.g] - b0, d * d);
      check({name, " opReq count"}, op_cnt[t.g] - o0, d * d * d);
      check({name, " done count"}, done_cnt[t.g] - n0, 1);
      check_log(t, b0, name);
      noise[t.g] = 1'b0;
   endtask
   initial begin
      int b0, o0, n0, n;
      v[0].g = 0; v[0].nz = 0;
      v[0].a = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
      v[0].b = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      v[0].c = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      v[1].g = 1; v[1].nz = 0;
      v[1].a = '{default: 8'd255};
      v[1].b = '{default: 8'd255};
      v[1].c = '{default: 32'd195075};
      v[2].g = 2; v[2].nz = 0;
      v[2].a = '{7, 0, 0, 0, 0, 0, 0, 0, 0};
      v[2].b = '{9, 0, 0, 0, 0, 0, 0, 0, 0};
      v[2].c = '{63, 0, 0, 0, 0, 0, 0, 0, 0};
      v[3].g = 0; v[3].nz = 0;
      v[3].a = '{default: 8'd0};
      v[3].b = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      v[3].c = '{default: 32'd0};
      v[4].g = 0; v[4].nz = 1;
      v[4].a = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      v[4].b = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
      v[4].c = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
      v[5].g = 1; v[5].nz = 1;
      v[5].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      v[5].b = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
      v[5].c = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
      v[6].g = 2; v[6].nz = 1;
      v[6].a = '{255, 0, 0, 0, 0, 0, 0, 0, 0};
      v[6].b = '{255, 0, 0, 0, 0, 0, 0, 0, 0};
      v[6].c = '{65025, 0, 0, 0, 0, 0, 0, 0, 0};
      repeat (3) tick();
      rst = 1'b0;
      for (int g = 0; g < NI; g++) begin
         check($sformatf("reset busy[%0d]", g), int'(o_busy[g]), 0);
         check($sformatf("reset opReq[%0d]", g), int'(o_op[g]), 0);
         check($sformatf("reset wrEn[%0d]", g), int'(o_wr[g]), 0);
         check($sformatf("reset done[%0d]", g), int'(o_done[g]), 0);
         check($sformatf("reset addrA[%0d]", g), o_addr_a[g], 0);
         check($sformatf("reset addrB[%0d]", g), o_addr_b[g], 0);
         check($sformatf("reset wrAddr[%0d]", g), o_wra[g], 0);
         check($sformatf("reset wrData[%0d]", g), o_wrd[g], 0);
      end
      for (int x = 0; x < 7; x++) run(v[x], $sformatf("vec%0d", x));
      // stray acum and genAddr while idle: nothing may move
      b0 = wr_cnt[0];
      ac_m[0] = 1'b1;
      tick();
      ac_m[0] = 1'b0;
      ga_m[0] = 1'b1;
      tick();
      ga_m[0] = 1'b0;
      tick();
      check("idle pulse busy", int'(o_busy[0]), 0);
      check("idle pulse opReq", int'(o_op[0]), 0);
      check("idle pulse wrData", o_wrd[0], 50);
      check("idle pulse wrAddr", o_wra[0], 3);
      check("idle pulse addrA", o_addr_a[0], 3);
      check("idle pulse addrB", o_addr_b[0], 3);
      check("idle pulse writes", wr_cnt[0] - b0, 0);
      // reset after the second write aborts the run
      load(v[0]);
      b0 = wr_cnt[0];
      n0 = done_cnt[0];
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      n = 0;
      while (wr_cnt[0] - b0 < 2 && n < 500) begin
         tick();
         n++;
      end
      check("abort writes before rst", wr_cnt[0] - b0, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", int'(o_busy[0]), 0);
      check("abort opReq", int'(o_op[0]), 0);
      repeat (30) tick();
      check("abort writes after rst", wr_cnt[0] - b0, 2);
      check("abort done", done_cnt[0] - n0, 0);
      run(v[0], "restart");
      // start held high: one full run, then a second only after returning to IDLE
      load(v[0]);
      b0 = wr_cnt[0];
      o0 = op_cnt[0];
      n0 = done_cnt[0];
      start[0] = 1'b1;
      wait_done(0, "held run1");
      tick();
      check("held idle busy", int'(o_busy[0]), 0);
      check("held run1 writes", wr_cnt[0] - b0, 4);
      check("held run1 opReq", op_cnt[0] - o0, 8);
      tick();
      check("held rerun busy", int'(o_busy[0]), 1);
      start[0] = 1'b0;
      wait_done(0, "held run2");
      tick();
      tick();
      check("held total writes", wr_cnt[0] - b0, 8);
      check("held total done", done_cnt[0] - n0, 2);
      check("held total opReq", op_cnt[0] - o0, 16);
      check_log(v[0], b0 + 4, "held run2");
      for (int g = 0; g < NI; g++) check($sformatf("single-cycle pulses[%0d]", g), pulse_err[g], 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
